// File: rtl/data_path_pkg.sv
// Shared definitions for the 8-bit computer datapath: bus width, ALU operation
// codes, bus source selects and CCR bit positions. control_unit imports the same
// package, so both blocks agree on every encoding.
// The optional logic/B-register ALU operations are enabled by DATA_PATH_LOGIC_OPS_EN.
package data_path_pkg;

    localparam int DP_WIDTH = 8;

    // ALU operation codes driven by control_unit on ALU_Sel
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_INC  = 3'b100,
        ALU_DEC  = 3'b101,
        ALU_INCB = 3'b110,
        ALU_DECB = 3'b111
    } alu_op_e;

    // Bus1 sources: feeds the ALU X operand and the memory write data
    typedef enum logic [1:0] {
        BUS1_PC   = 2'b00,
        BUS1_A    = 2'b01,
        BUS1_B    = 2'b10,
        BUS1_ZERO = 2'b11
    } bus1_sel_e;

    // Bus2 sources: the single write-back bus every register loads from
    typedef enum logic [1:0] {
        BUS2_ALU  = 2'b00,
        BUS2_BUS1 = 2'b01,
        BUS2_MEM  = 2'b10,
        BUS2_ZERO = 2'b11
    } bus2_sel_e;

    // Condition code bit positions inside CCR_Result = {N,Z,V,C}
    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

endpackage

// File: rtl/data_path_if.sv
// Control and memory bundle between control_unit/memory (master side) and the
// datapath (slave side). Carries the per-cycle load strobes, the bus/ALU selects,
// the memory read data and the datapath results returned to the sequencer.
interface data_path_if;
    import data_path_pkg::*;

    logic                IR_Load;
    logic                MAR_Load;
    logic                PC_Load;
    logic                PC_Inc;
    logic                A_Load;
    logic                B_Load;
    logic                CCR_Load;
    logic [2:0]          ALU_Sel;
    logic [1:0]          Bus1_Sel;
    logic [1:0]          Bus2_Sel;
    logic [DP_WIDTH-1:0] from_memory;
    logic [DP_WIDTH-1:0] address;
    logic [DP_WIDTH-1:0] to_memory;
    logic [DP_WIDTH-1:0] IR;
    logic [3:0]          CCR_Result;

    modport master (
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
        output ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
        input  address, to_memory, IR, CCR_Result
    );

    modport slave (
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
        input  ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
        output address, to_memory, IR, CCR_Result
    );

endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU: X comes from Bus1, Y from the B register. A 9-bit internal
// sum provides carry/borrow; N and Z are always derived from the 8-bit result.
// DATA_PATH_LOGIC_OPS_EN adds AND, OR, INCB and DECB; without it those codes
// pass X straight through with V=C=0.
module data_path_alu
    import data_path_pkg::*;
(
    input  logic [DP_WIDTH-1:0] i_x,
    input  logic [DP_WIDTH-1:0] i_y,
    input  logic [2:0]          i_aluSel,
    output logic [DP_WIDTH-1:0] o_result,
    output logic [3:0]          o_nzvc
);

    logic [DP_WIDTH:0]   w_sum;
    logic [DP_WIDTH-1:0] w_result;
    logic                w_v;
    logic                w_c;

    // Operation decode; unused codes fall back to X pass-through with clear V/C
    always_comb begin
        w_sum    = '0;
        w_result = i_x;
        w_v      = 1'b0;
        w_c      = 1'b0;
        case (i_aluSel)
            ALU_ADD: begin
                w_sum    = {1'b0, i_x} + {1'b0, i_y};
                w_result = w_sum[DP_WIDTH-1:0];
                w_c      = w_sum[DP_WIDTH];
                w_v      = (i_x[DP_WIDTH-1] == i_y[DP_WIDTH-1]) &&
                           (w_sum[DP_WIDTH-1] != i_x[DP_WIDTH-1]);
            end
            ALU_SUB: begin
                w_sum    = {1'b0, i_x} - {1'b0, i_y};
                w_result = w_sum[DP_WIDTH-1:0];
                w_c      = w_sum[DP_WIDTH];
                w_v      = (i_x[DP_WIDTH-1] != i_y[DP_WIDTH-1]) &&
                           (w_sum[DP_WIDTH-1] != i_x[DP_WIDTH-1]);
            end
            ALU_INC: begin
                w_sum    = {1'b0, i_x} + 9'd1;
                w_result = w_sum[DP_WIDTH-1:0];
                w_c      = w_sum[DP_WIDTH];
                w_v      = (i_x == 8'h7F);
            end
            ALU_DEC: begin
                w_sum    = {1'b0, i_x} - 9'd1;
                w_result = w_sum[DP_WIDTH-1:0];
                w_c      = w_sum[DP_WIDTH];
                w_v      = (i_x == 8'h80);
            end
`ifdef DATA_PATH_LOGIC_OPS_EN
            ALU_AND: begin
                w_result = i_x & i_y;
            end
            ALU_OR: begin
                w_result = i_x | i_y;
            end
            ALU_INCB: begin
                w_sum    = {1'b0, i_y} + 9'd1;
                w_result = w_sum[DP_WIDTH-1:0];
                w_c      = w_sum[DP_WIDTH];
                w_v      = (i_y == 8'h7F);
            end
            ALU_DECB: begin
                w_sum    = {1'b0, i_y} - 9'd1;
                w_result = w_sum[DP_WIDTH-1:0];
                w_c      = w_sum[DP_WIDTH];
                w_v      = (i_y == 8'h80);
            end
`endif
            default: begin
                w_result = i_x;
            end
        endcase
    end

    assign o_result = w_result;
    assign o_nzvc   = {w_result[DP_WIDTH-1], (w_result == '0), w_v, w_c};

endmodule

// File: rtl/data_path.sv
// Register/bus datapath of the 8-bit computer. Executes the load and select
// strobes issued each cycle by control_unit, drives MAR and write data to memory,
// and returns IR and the NZVC condition codes. No sequencing lives here.
// Optional ALU operations are enabled with DATA_PATH_LOGIC_OPS_EN (see data_path_alu).
module data_path
    import data_path_pkg::*;
#(
    parameter int                  DATA_W   = DP_WIDTH,
    parameter logic [DP_WIDTH-1:0] PC_RESET = 8'h00
)(
    input  logic          clk,
    input  logic          reset,
    data_path_if.slave    io_bus
);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [3:0]        r_ccr;

    logic [DATA_W-1:0] w_bus1;
    logic [DATA_W-1:0] w_bus2;
    logic [DATA_W-1:0] w_aluResult;
    logic [3:0]        w_aluNzvc;

    // Bus1 source mux; the spare select drives a defined zero
    always_comb begin
        w_bus1 = '0;
        case (io_bus.Bus1_Sel)
            BUS1_PC:   w_bus1 = r_pc;
            BUS1_A:    w_bus1 = r_a;
            BUS1_B:    w_bus1 = r_b;
            default:   w_bus1 = '0;
        endcase
    end

    // Bus2 source mux shared by every register load
    always_comb begin
        w_bus2 = '0;
        case (io_bus.Bus2_Sel)
            BUS2_ALU:  w_bus2 = w_aluResult;
            BUS2_BUS1: w_bus2 = w_bus1;
            BUS2_MEM:  w_bus2 = io_bus.from_memory;
            default:   w_bus2 = '0;
        endcase
    end

    data_path_alu u_alu (
        .i_x      (w_bus1),
        .i_y      (r_b),
        .i_aluSel (io_bus.ALU_Sel),
        .o_result (w_aluResult),
        .o_nzvc   (w_aluNzvc)
    );

    // Program counter: an explicit load overrides the increment, which wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= PC_RESET;
        end else if (io_bus.PC_Load) begin
            r_pc <= w_bus2;
        end else if (io_bus.PC_Inc) begin
            r_pc <= r_pc + DATA_W'(1);
        end
    end

    // IR, MAR, A and B each load independently from the same Bus2 value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir  <= '0;
            r_mar <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else begin
            if (io_bus.IR_Load)  r_ir  <= w_bus2;
            if (io_bus.MAR_Load) r_mar <= w_bus2;
            if (io_bus.A_Load)   r_a   <= w_bus2;
            if (io_bus.B_Load)   r_b   <= w_bus2;
        end
    end

    // Condition codes capture the current ALU flags only when asked to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ccr <= 4'b0000;
        end else if (io_bus.CCR_Load) begin
            r_ccr <= w_aluNzvc;
        end
    end

    assign io_bus.address    = r_mar;
    assign io_bus.to_memory  = w_bus1;
    assign io_bus.IR         = r_ir;
    assign io_bus.CCR_Result = r_ccr;

endmodule
